sipo_deserializer: RTL
======================

Name: sipo_deserializer

Overview:
- Serial-in/parallel-out receiver: the far end of the 4-bit PISO serial link.
- Reassembles WIDTH-bit words from the serial line, using the transmitter's SH_LDN load strobe as the frame marker.
- Presents each complete word with a one-cycle VALID strobe, flags truncated frames and counts good words.
- Sits on the receive side of the chapter-2 shift-register link, clocked by the same CLK as the transmitter.

Parameters:
- WIDTH, 4: bits per word, ≥2.
- MSB_FIRST, 1: 1 = first received bit lands in Q[WIDTH-1]; 0 = first received bit lands in Q[0].
- CNT_W, 8: width of the good-word counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- SH_LDN  input  1  frame marker from transmitter; 0 = load cycle (new word starts), 1 = shift cycle.
- SI  input  1  serial data from transmitter Q.
- Q  output  WIDTH  last complete received word.
- VALID  output  1  one-cycle strobe: Q just updated with a new word.
- FRAME_ERR  output  1  one-cycle strobe: previous frame aborted before WIDTH bits.
- BUSY  output  1  1 while a frame is being received.
- WORD_CNT  output  CNT_W  count of good words, saturating.

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high (CLK, RST).
- Reset (RST=1 at an edge):
  - Clears state to IDLE, bit counter and shift register to 0.
  - Clears Q=0, VALID=0, FRAME_ERR=0, BUSY=0, WORD_CNT=0.
  - RST overrides all other inputs, including mid-frame; a partial word is discarded and no FRAME_ERR is raised.
- States:
  - IDLE: BUSY=0.
  - RECV: BUSY=1. Internal bit counter bitcnt runs 0..WIDTH-1.
- IDLE:
  - SH_LDN=0 at an edge -> RECV, bitcnt=0. No bit is captured on that edge.
  - SH_LDN=1 -> stay IDLE; SI is ignored. Trailing fill bits from the transmitter produce nothing.
- RECV, SH_LDN=1 at an edge:
  - Capture SI into the shift register.
  - MSB_FIRST=1: shift left, insert at bit 0. MSB_FIRST=0: shift right, insert at bit WIDTH-1.
  - Then bitcnt+1.
- Completion, on the edge capturing bit WIDTH-1:
  - Q <= assembled word including this bit.
  - VALID=1 for exactly the following cycle.
  - WORD_CNT+1, saturating at 2^CNT_W-1.
  - State -> IDLE.
  - Latency: VALID is high the cycle after the edge that samples the last bit.
- RECV, SH_LDN=0 at an edge (premature marker):
  - FRAME_ERR=1 for the following cycle.
  - Partial word discarded; Q, VALID and WORD_CNT unchanged.
  - Restart RECV with bitcnt=0; this marker begins the new frame.
- Completion edge with SH_LDN=0 is impossible: completion requires SH_LDN=1.
- SH_LDN=0 on the cycle right after completion (VALID high): a legal new frame. No error, BUSY returns to 1.
- Repeated SH_LDN=0 in IDLE: stays in RECV with bitcnt=0. No error, because no bits have been captured.
- VALID and FRAME_ERR are never high in the same cycle.
- Q holds its value between words.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Basic 1101, MSB_FIRST=1, WIDTH=4:
  - Stimulus: RST for 2 cycles; SH_LDN=0 one cycle; then SH_LDN=1 with SI=1,1,0,1.
  - Response: Q=4'b1101 and VALID=1 exactly one cycle after the 4th shift edge; WORD_CNT=1; BUSY 1 for 4 cycles, then 0.
- Back-to-back words:
  - Stimulus: frame 1101, then marker, then 0010, with SI held 0 for 20 idle shift cycles in between.
  - Response: exactly two VALID pulses with Q=1101 then Q=0010; no VALID during the idle shifts; WORD_CNT=2.
- Truncated frame:
  - Stimulus: marker, SI=1,0, marker, then SI=1,0,1,0.
  - Response: FRAME_ERR pulse on the cycle after the second marker; Q unchanged; then Q=4'b1010 with VALID; WORD_CNT+1 only once.
- Reset mid-frame:
  - Stimulus: marker, SI=1,1, then RST one cycle, then SI=1,1 with SH_LDN=1.
  - Response: all outputs 0 after RST; no VALID and no FRAME_ERR afterwards.
- LSB-first:
  - Stimulus: MSB_FIRST=0, marker, SI=1,0,1,1.
  - Response: Q=4'b1101, VALID pulse.
- Saturation:
  - Stimulus: CNT_W=2, six good frames.
  - Response: WORD_CNT goes 1,2,3,3,3,3; VALID pulses all six times.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// Serial link receive-side bundle: transmitter strobe/data in, reassembled word and status out.
interface sipo_deserializer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             sh_ldn;
   logic             si;
   logic [WIDTH-1:0] q;
   logic             valid;
   logic             frame_err;
   logic             busy;
   logic [CNT_W-1:0] word_cnt;

   modport master (
      output sh_ldn, si,
      input  q, valid, frame_err, busy, word_cnt
   );

   modport slave (
      input  sh_ldn, si,
      output q, valid, frame_err, busy, word_cnt
   );
endinterface

// File: rtl/sipo_deserializer.sv
// SIPO receiver: rebuilds WIDTH-bit words framed by the transmitter's load strobe (sh_ldn low).
module sipo_deserializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = 8
) (
   input  logic clk,
   input  logic rst,
   sipo_deserializer_if.slave bus
);
   localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0]    LAST    = BW'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {IDLE, RECV} state_t;

   state_t           state;
   logic [BW-1:0]    bitcnt;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_nxt;
   logic [WIDTH-1:0] q;
   logic             valid;
   logic             frame_err;
   logic             busy;
   logic [CNT_W-1:0] word_cnt;

   generate
      if (MSB_FIRST) begin : g_msb
         assign sr_nxt = {sr[WIDTH-2:0], bus.si};
      end else begin : g_lsb
         assign sr_nxt = {bus.si, sr[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bitcnt    <= '0;
         sr        <= '0;
         q         <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
         word_cnt  <= '0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!bus.sh_ldn) begin
                  state  <= RECV;
                  busy   <= 1'b1;
                  bitcnt <= '0;
                  sr     <= '0;
               end
            end
            RECV: begin
               if (!bus.sh_ldn) begin
                  // A marker before any bit was taken just re-arms the frame, not an error.
                  frame_err <= (bitcnt != '0);
                  bitcnt    <= '0;
                  sr        <= '0;
               end else if (bitcnt == LAST) begin
                  q      <= sr_nxt;
                  sr     <= sr_nxt;
                  valid  <= 1'b1;
                  state  <= IDLE;
                  busy   <= 1'b0;
                  bitcnt <= '0;
                  if (word_cnt != CNT_MAX) word_cnt <= word_cnt + 1'b1;
               end else begin
                  sr     <= sr_nxt;
                  bitcnt <= bitcnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.q         = q;
   assign bus.valid     = valid;
   assign bus.frame_err = frame_err;
   assign bus.busy      = busy;
   assign bus.word_cnt  = word_cnt;

   always_ff @(posedge clk) begin
      if (!rst) assert (!(valid && frame_err));
   end
endmodule
